ppfifo_multichannel: RTL and testbench
======================================

# ppfifo_multichannel

Parametrised, multi-channel successor to the single-channel ppfifo. It exposes the same four-phase put/get request-acknowledge interface plus a synchronous clear. It adds CHANNELS independent FIFO queues of DEPTH words each, selected per transaction, with per-channel full and empty flags. It sits between the writer and reader agents of the ppfifo test environment and drops in wherever several logical streams share one handshake port pair.

## Interface
- WORD_SIZE, 8: data width in bits, ≥1.
- DEPTH, 4: words per channel; power of 2, ≥2.
- CHANNELS, 4: number of queues, ≥1. CH_BITS = max(1, $clog2(CHANNELS)). CNT_BITS = $clog2(DEPTH)+1.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous flush of all channels.
- put_req  in  1  writer request (four-phase).
- put_channel  in  CH_BITS  target channel, stable while put_req high.
- put_value  in  WORD_SIZE  data, stable while put_req high.
- put_ack  out  1  write acknowledge.
- get_req  in  1  reader request (four-phase).
- get_channel  in  CH_BITS  source channel, stable while get_req high.
- get_value  out  WORD_SIZE  read data, valid while get_ack high.
- get_ack  out  1  read acknowledge.
- full  out  CHANNELS  bit c high when channel c holds DEPTH words.
- empty  out  CHANNELS  bit c high when channel c holds 0 words.
- channel_error  out  1  one-cycle pulse on a request to a channel index ≥ CHANNELS.

## Operation
- Storage: CHANNELS×DEPTH words. Per channel: write pointer, read pointer ($clog2(DEPTH) bits, natural wrap) and count (CNT_BITS).
- Writer FSM, W_IDLE / W_ACK:
  - W_IDLE with put_req=1, clear=0, channel valid and full[put_channel]=0: store put_value at the channel write pointer, advance the pointer, increment count, set put_ack=1, go to W_ACK.
  - W_IDLE with channel full: no action; put_ack stays 0 and the request waits.
  - W_ACK: put_ack holds 1 until put_req is sampled 0. Then put_ack=0 and the FSM returns to W_IDLE.
- Reader FSM, R_IDLE / R_ACK:
  - R_IDLE with get_req=1, clear=0, channel valid and empty[get_channel]=0: load the head word into get_value, advance the read pointer, decrement count, set get_ack=1, go to R_ACK.
  - R_IDLE with channel empty: the request waits.
  - R_ACK: get_ack and get_value hold until get_req is sampled 0. Then get_ack=0, get_value keeps its last value, and the FSM returns to R_IDLE.
- Invalid channel index (only possible when CHANNELS is not a power of 2):
  - Put: acknowledged and discarded.
  - Get: acknowledged with get_value=0.
  - channel_error pulses in the acceptance cycle.
- Clear: zeroes all pointers and counts. Memory contents are not cleared. Clear does not disturb an FSM already in W_ACK or R_ACK. A request arriving in a clear cycle is not accepted until clear=0.
- Flags are registered and derived from the post-edge count: full = (count==DEPTH), empty = (count==0).

## Timing
- Reset values: put_ack=0, get_ack=0, get_value=0, channel_error=0, full=all 0, empty=all 1, both FSMs idle, all counts and pointers 0.
- Accept latency: a request sampled at edge N sets its ack high after edge N. The written word is stored at edge N.
- Release: a request seen low at edge M sets its ack low after edge M. The earliest next acceptance is edge M+1, so the minimum handshake is 2 cycles per word.
- Same-cycle put and get:
  - Different channels: independent.
  - Same channel: count is unchanged.
  - Put into an empty channel is not visible to a get at the same edge; the get waits one cycle.
  - Get from a full channel frees space at that edge; a waiting put is accepted at the next edge.
- Pointer wrap: after DEPTH writes the write pointer returns to 0; ordering is preserved across the wrap.
- Reset mid-handshake forces the acks low immediately. The requester must restart the transaction.

## Test plan
- Reset, then idle 5 cycles -> empty=4'b1111, full=4'b0000, both acks 0, get_value=0.
- Put 0x11,0x22,0x33,0x44 to ch2, then get ch2 ×4 -> get_value 0x11,0x22,0x33,0x44 in order; empty[2] returns to 1; other channels untouched.
- Put 4 words to ch0 -> full[0]=1. A fifth put (0x55) gets no put_ack. Get ch0 -> 0x01, and the pending put is then acknowledged. Further gets -> remaining three original words then 0x55 (wrap verified).
- Interleave puts ch1=0xA0, ch3=0xB0, ch1=0xA1 -> get ch3 = 0xB0, then ch1 = 0xA0, 0xA1: channels are isolated.
- Load ch0 with 3 words, pulse clear for 1 cycle -> empty[0]=1. get ch0 stalls until a new put of 0x7E, then returns 0x7E.
- Simultaneous put ch1 / get ch1 with count=2 -> count stays 2 and flags are unchanged. Assert reset during put_ack=1 -> put_ack=0 at once and empty=all 1.

Source files
------------

// File: rtl/ppfifo_multichannel.sv
// ----------------------------------------------------------------------------
// ppfifo_multichannel
//
// Multi-channel ping-pong FIFO behind one four-phase put/get handshake pair.
// CHANNELS independent queues of DEPTH words each. Every transaction picks its
// queue with put_channel / get_channel. Writer and reader are separate
// two-state FSMs, so a put and a get can be accepted on the same edge.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high
//   clear          in   synchronous flush of every channel's pointers/counts
//   put_req        in   writer request (four-phase)
//   put_channel    in   target channel, held stable while put_req is high
//   put_value      in   write data, held stable while put_req is high
//   put_ack        out  write acknowledge
//   get_req        in   reader request (four-phase)
//   get_channel    in   source channel, held stable while get_req is high
//   get_value      out  read data, valid while get_ack is high, then held
//   get_ack        out  read acknowledge
//   full           out  bit c set when channel c holds DEPTH words
//   empty          out  bit c set when channel c holds no words
//   channel_error  out  one-cycle pulse when a request names a channel that
//                       does not exist
// ----------------------------------------------------------------------------
module ppfifo_multichannel #(
    parameter  int WORD_SIZE = 8,
    parameter  int DEPTH     = 4,
    parameter  int CHANNELS  = 4,
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_BITS  = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 put_req,
    input  logic [CH_BITS-1:0]   put_channel,
    input  logic [WORD_SIZE-1:0] put_value,
    output logic                 put_ack,
    input  logic                 get_req,
    input  logic [CH_BITS-1:0]   get_channel,
    output logic [WORD_SIZE-1:0] get_value,
    output logic                 get_ack,
    output logic [CHANNELS-1:0]  full,
    output logic [CHANNELS-1:0]  empty,
    output logic                 channel_error
);

    localparam int                  PTR_BITS   = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    typedef enum logic {W_IDLE, W_ACK} w_state_t;
    typedef enum logic {R_IDLE, R_ACK} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [WORD_SIZE-1:0] mem    [CHANNELS][DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr [CHANNELS];
    logic [PTR_BITS-1:0]  rd_ptr [CHANNELS];
    logic [CNT_BITS-1:0]  count  [CHANNELS];
    logic [CNT_BITS-1:0]  count_next [CHANNELS];

    logic [CHANNELS-1:0]  put_sel;
    logic [CHANNELS-1:0]  get_sel;
    logic [WORD_SIZE-1:0] head_word;
    logic                 put_valid;
    logic                 get_valid;
    logic                 put_accept;
    logic                 get_accept;

    // Channel decode. An index with no matching channel leaves the select
    // vector all zero. That request is therefore never blocked by a flag.
    // Its read data is zero.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        put_sel   = '0;
        get_sel   = '0;
        head_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (put_channel == CH_BITS'(c)) begin
                put_sel[c] = 1'b1;
            end
            if (get_channel == CH_BITS'(c)) begin
                get_sel[c] = 1'b1;
                head_word  = mem[c][rd_ptr[c]];
            end
        end
    end

    assign put_valid = |put_sel;
    assign get_valid = |get_sel;

    // The registered flags are used here. A put into an empty channel is
    // therefore invisible to a get on the same edge, and space freed by a
    // get is only seen by a put on the following edge.
    assign put_accept = (w_state == W_IDLE) && put_req && !clear && !(|(put_sel & full));
    assign get_accept = (r_state == R_IDLE) && get_req && !clear && !(|(get_sel & empty));

    // Writer and reader next-state logic
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE: if (put_accept) w_state_next = W_ACK;
            W_ACK:  if (!put_req)   w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE: if (get_accept) r_state_next = R_ACK;
            R_ACK:  if (!get_req)   r_state_next = R_IDLE;
        endcase
    end

    assign put_ack = (w_state == W_ACK);
    assign get_ack = (r_state == R_ACK);

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, whatever the statement order.
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    // A same-channel put and get on one edge leave the count unchanged.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            count_next[c] = count[c];
            if ((put_accept && put_sel[c]) && !(get_accept && get_sel[c])) begin
                count_next[c] = count[c] + CNT_BITS'(1);
            end else if ((get_accept && get_sel[c]) && !(put_accept && put_sel[c])) begin
                count_next[c] = count[c] - CNT_BITS'(1);
            end
        end
    end

    // Pointers, counts and flags. Clear flushes bookkeeping only. No request
    // is accepted while clear is high, so no update can be lost here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            full  <= '0;
            empty <= '1;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            full  <= '0;
            empty <= '1;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (put_accept && put_sel[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_BITS'(1);
                end
                if (get_accept && get_sel[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_BITS'(1);
                end
                count[c] <= count_next[c];
                full[c]  <= (count_next[c] == FULL_COUNT);
                empty[c] <= (count_next[c] == '0);
            end
        end
    end

    // NOTE: storage has no reset. Its contents are only observable through
    // the counts, which are reset, so stale words can never be read.
    always_ff @(posedge clock) begin
        if (put_accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (put_sel[c]) begin
                    mem[c][wr_ptr[c]] <= put_value;
                end
            end
        end
    end

    // Read data register and error pulse. The error is only raised in an
    // acceptance cycle. The FSM then sits in its ACK state, so the error
    // lasts exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            get_value     <= '0;
            channel_error <= 1'b0;
        end else begin
            channel_error <= (put_accept && !put_valid) || (get_accept && !get_valid);
            if (get_accept) begin
                get_value <= head_word;
            end
        end
    end

endmodule

// File: tb/tb_ppfifo_multichannel.sv
// ----------------------------------------------------------------------------
// tb_ppfifo_multichannel
//
// Self-checking bench for ppfifo_multichannel with default parameters. The
// reference is one queue per channel. A put is expected to complete when its
// queue is short of DEPTH words. A get is expected to return the queue head
// when the queue is not empty.
// ----------------------------------------------------------------------------
module tb_ppfifo_multichannel;

    localparam int WS    = 8;
    localparam int DEPTH = 4;
    localparam int CH    = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          put_req;
    logic [1:0]    put_channel;
    logic [WS-1:0] put_value;
    logic          put_ack;
    logic          get_req;
    logic [1:0]    get_channel;
    logic [WS-1:0] get_value;
    logic          get_ack;
    logic [CH-1:0] full;
    logic [CH-1:0] empty;
    logic          channel_error;

    int vectors     = 0;
    int miscompares = 0;
    bit err_seen    = 1'b0;

    logic [WS-1:0] model_q [CH][$];

    ppfifo_multichannel #(.WORD_SIZE(WS), .DEPTH(DEPTH), .CHANNELS(CH)) dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .put_req       (put_req),
        .put_channel   (put_channel),
        .put_value     (put_value),
        .put_ack       (put_ack),
        .get_req       (get_req),
        .get_channel   (get_channel),
        .get_value     (get_value),
        .get_ack       (get_ack),
        .full          (full),
        .empty         (empty),
        .channel_error (channel_error)
    );

    always #5 clock = ~clock;

    // Every channel index exists with CHANNELS=4, so channel_error must never fire.
    always @(negedge clock) if (channel_error) err_seen = 1'b1;

    typedef enum {OP_PUT, OP_GET} op_t;
    typedef struct {
        op_t           op;
        int            ch;
        logic [WS-1:0] data;
        logic [CH-1:0] exp_full;
        logic [CH-1:0] exp_empty;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [CH-1:0] m_empty();
        logic [CH-1:0] e;
        for (int c = 0; c < CH; c++) e[c] = (model_q[c].size() == 0);
        return e;
    endfunction

    function automatic logic [CH-1:0] m_full();
        logic [CH-1:0] f;
        for (int c = 0; c < CH; c++) f[c] = (model_q[c].size() == DEPTH);
        return f;
    endfunction

    task automatic check_flags(input string name);
        check({name, "_full"},  32'(full),  32'(m_full()));
        check({name, "_empty"}, 32'(empty), 32'(m_empty()));
    endtask

    task automatic model_flush();
        for (int c = 0; c < CH; c++) model_q[c].delete();
    endtask

    // Full put handshake. The request is raised at a negedge. If the model
    // has room, the ack must be visible at the very next negedge. Otherwise
    // no ack may appear within 3 cycles, and the request is then withdrawn.
    task automatic do_put(input int ch, input logic [WS-1:0] val);
        bit expect_ok;
        int lat;
        expect_ok   = (model_q[ch].size() < DEPTH);
        lat         = -1;
        put_channel = 2'(ch);
        put_value   = val;
        put_req     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (put_ack) begin
                lat = i;
                break;
            end
        end
        if (expect_ok) begin
            check("put_latency", 32'(lat), 32'(0));
            model_q[ch].push_back(val);
        end else begin
            check("put_stall_full", 32'(lat), 32'(-1));
        end
        put_req = 1'b0;
        @(negedge clock);
        check("put_release", 32'(put_ack), 32'(0));
        check_flags("put");
    endtask

    task automatic do_get(input int ch, output logic [WS-1:0] got);
        bit            expect_ok;
        int            lat;
        logic [WS-1:0] exp;
        expect_ok   = (model_q[ch].size() > 0);
        exp         = expect_ok ? model_q[ch][0] : '0;
        lat         = -1;
        got         = '0;
        get_channel = 2'(ch);
        get_req     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (get_ack) begin
                lat = i;
                got = get_value;
                break;
            end
        end
        if (expect_ok) begin
            check("get_latency", 32'(lat), 32'(0));
            check("get_value", 32'(got), 32'(exp));
            void'(model_q[ch].pop_front());
        end else begin
            check("get_stall_empty", 32'(lat), 32'(-1));
        end
        get_req = 1'b0;
        @(negedge clock);
        check("get_release", 32'(get_ack), 32'(0));
        if (expect_ok) check("get_value_hold", 32'(get_value), 32'(exp));
        check_flags("get");
    endtask

    initial begin
        logic [WS-1:0] got;

        vecs[0]  = '{OP_PUT, 2, 8'h11, 4'b0000, 4'b1011};
        vecs[1]  = '{OP_PUT, 2, 8'h22, 4'b0000, 4'b1011};
        vecs[2]  = '{OP_PUT, 2, 8'h33, 4'b0000, 4'b1011};
        vecs[3]  = '{OP_PUT, 2, 8'h44, 4'b0100, 4'b1011};
        vecs[4]  = '{OP_GET, 2, 8'h11, 4'b0000, 4'b1011};
        vecs[5]  = '{OP_GET, 2, 8'h22, 4'b0000, 4'b1011};
        vecs[6]  = '{OP_GET, 2, 8'h33, 4'b0000, 4'b1011};
        vecs[7]  = '{OP_GET, 2, 8'h44, 4'b0000, 4'b1111};
        vecs[8]  = '{OP_PUT, 1, 8'hA0, 4'b0000, 4'b1101};
        vecs[9]  = '{OP_PUT, 3, 8'hB0, 4'b0000, 4'b0101};
        vecs[10] = '{OP_PUT, 1, 8'hA1, 4'b0000, 4'b0101};
        vecs[11] = '{OP_GET, 3, 8'hB0, 4'b0000, 4'b1101};
        vecs[12] = '{OP_GET, 1, 8'hA0, 4'b0000, 4'b1101};
        vecs[13] = '{OP_GET, 1, 8'hA1, 4'b0000, 4'b1111};

        reset       = 1'b1;
        clear       = 1'b0;
        put_req     = 1'b0;
        get_req     = 1'b0;
        put_channel = '0;
        get_channel = '0;
        put_value   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Reset state
        check("rst_empty", 32'(empty), 32'(4'b1111));
        check("rst_full", 32'(full), 32'(4'b0000));
        check("rst_put_ack", 32'(put_ack), 32'(0));
        check("rst_get_ack", 32'(get_ack), 32'(0));
        check("rst_get_value", 32'(get_value), 32'(0));

        // Ordered fill/drain of ch2, then channel isolation across ch1/ch3
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].op == OP_PUT) begin
                do_put(vecs[i].ch, vecs[i].data);
            end else begin
                do_get(vecs[i].ch, got);
                check("tbl_get_value", 32'(got), 32'(vecs[i].data));
            end
            check("tbl_full", 32'(full), 32'(vecs[i].exp_full));
            check("tbl_empty", 32'(empty), 32'(vecs[i].exp_empty));
        end

        // Full channel: a pending put waits, is released by a get, wraps
        for (int i = 0; i < 4; i++) do_put(0, 8'(i + 1));
        check("ch0_full", 32'(full), 32'(4'b0001));
        put_channel = 2'd0;
        put_value   = 8'h55;
        put_req     = 1'b1;
        repeat (3) @(negedge clock);
        check("full_put_waits", 32'(put_ack), 32'(0));
        get_channel = 2'd0;
        get_req     = 1'b1;
        @(negedge clock);
        check("free_get_ack", 32'(get_ack), 32'(1));
        check("free_get_value", 32'(get_value), 32'(8'h01));
        check("put_not_yet", 32'(put_ack), 32'(0));
        void'(model_q[0].pop_front());
        get_req = 1'b0;
        @(negedge clock);
        check("pending_put_ack", 32'(put_ack), 32'(1));
        check("get_released", 32'(get_ack), 32'(0));
        model_q[0].push_back(8'h55);
        put_req = 1'b0;
        @(negedge clock);
        check("pending_put_release", 32'(put_ack), 32'(0));
        for (int i = 0; i < 4; i++) do_get(0, got);
        check("wrap_last_word", 32'(got), 32'(8'h55));

        // Clear flushes ch0, blocks a request raised during clear
        for (int i = 0; i < 3; i++) do_put(0, 8'(8'h31 + i));
        clear       = 1'b1;
        put_channel = 2'd3;
        put_value   = 8'h9C;
        put_req     = 1'b1;
        @(negedge clock);
        check("clear_blocks_put", 32'(put_ack), 32'(0));
        check("clear_empty", 32'(empty), 32'(4'b1111));
        check("clear_full", 32'(full), 32'(4'b0000));
        clear = 1'b0;
        model_flush();
        @(negedge clock);
        check("after_clear_put_ack", 32'(put_ack), 32'(1));
        model_q[3].push_back(8'h9C);
        put_req = 1'b0;
        @(negedge clock);
        get_channel = 2'd0;
        get_req     = 1'b1;
        repeat (3) @(negedge clock);
        check("cleared_get_stalls", 32'(get_ack), 32'(0));
        put_channel = 2'd0;
        put_value   = 8'h7E;
        put_req     = 1'b1;
        @(negedge clock);
        check("refill_put_ack", 32'(put_ack), 32'(1));
        check("refill_get_waits", 32'(get_ack), 32'(0));
        put_req = 1'b0;
        @(negedge clock);
        check("refill_get_ack", 32'(get_ack), 32'(1));
        check("refill_get_value", 32'(get_value), 32'(8'h7E));
        get_req = 1'b0;
        @(negedge clock);
        check_flags("refill");
        do_get(3, got);

        // Same-channel put and get on one edge with two words stored
        do_put(1, 8'hC1);
        do_put(1, 8'hC2);
        put_channel = 2'd1;
        put_value   = 8'hC3;
        get_channel = 2'd1;
        put_req     = 1'b1;
        get_req     = 1'b1;
        @(negedge clock);
        check("same_put_ack", 32'(put_ack), 32'(1));
        check("same_get_ack", 32'(get_ack), 32'(1));
        check("same_get_value", 32'(get_value), 32'(8'hC1));
        void'(model_q[1].pop_front());
        model_q[1].push_back(8'hC3);
        check_flags("same");
        put_req = 1'b0;
        get_req = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) do_get(1, got);

        // Reset while put_ack is high
        put_channel = 2'd2;
        put_value   = 8'h5A;
        put_req     = 1'b1;
        @(negedge clock);
        check("pre_reset_put_ack", 32'(put_ack), 32'(1));
        check("pre_reset_empty", 32'(empty), 32'(4'b1011));
        reset = 1'b1;
        #1;
        check("reset_put_ack", 32'(put_ack), 32'(0));
        check("reset_empty", 32'(empty), 32'(4'b1111));
        check("reset_full", 32'(full), 32'(4'b0000));
        check("reset_get_value", 32'(get_value), 32'(0));
        put_req = 1'b0;
        model_flush();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Random traffic against the queue model
        repeat (300) begin
            int r;
            int ch;
            r  = int'($urandom_range(0, 19));
            ch = int'($urandom_range(0, CH - 1));
            if (r == 0) begin
                clear = 1'b1;
                @(negedge clock);
                clear = 1'b0;
                model_flush();
                check_flags("rand_clear");
            end else if (r < 10) begin
                do_put(ch, 8'($urandom));
            end else begin
                do_get(ch, got);
            end
        end

        check("channel_error_quiet", 32'(err_seen), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
